// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// The state encoding is fixed so that other blocks and debug tooling can rely on it.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit adder cells for the serial adder datapath.
// A full adder is built from two half adders, with an OR gate merging their carries.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  half_adder u_ha1 (
    .i_a (w_s1),
    .i_b (i_cin),
    .o_s (o_s),
    .o_c (w_c2)
  );

  assign o_cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts an operand pair, adds LSB-first one bit per clock,
// then holds the sum and carry-out until the downstream consumer takes them.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-2:0]   r_acc;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic               w_s;
  logic               w_c;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_shift;

  full_adder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_c)
  );

  // in_ready is gated by rst_n so it reads low for the whole time reset is held.
  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_shift   = {w_s, r_acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)  w_next = S_RUN;
      S_RUN:  if (w_last)    w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  // Partial sum bits collect in r_acc; r_sum only changes when a full result
  // completes, so the visible outputs never show a partial value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          r_acc   <= w_shift[WIDTH-1:1];
          if (w_last) begin
            r_sum  <= w_shift;
            r_cout <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder: an 8-bit instance for the functional scenarios
// and a 3-bit instance swept over every operand pair.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       inValid8 = 1'b0;
  logic       inReady8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       outValid8;
  logic       outReady8 = 1'b0;
  logic [7:0] sum8;
  logic       cout8;

  logic       inValid3 = 1'b0;
  logic       inReady3;
  logic [2:0] a3 = '0;
  logic [2:0] b3 = '0;
  logic       outValid3;
  logic       outReady3 = 1'b0;
  logic [2:0] sum3;
  logic       cout3;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid8),
    .in_ready  (inReady8),
    .a         (a8),
    .b         (b8),
    .out_valid (outValid8),
    .out_ready (outReady8),
    .sum       (sum8),
    .cout      (cout8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid3),
    .in_ready  (inReady3),
    .a         (a3),
    .b         (b3),
    .out_valid (outValid3),
    .out_ready (outReady3),
    .sum       (sum3),
    .cout      (cout3)
  );

  // Drives one full transaction on the 8-bit instance, starting just after an edge in IDLE.
  // Returns the result and the number of edges from the accept edge to out_valid.
  task automatic runOp8(input logic [7:0] aIn, input logic [7:0] bIn,
                        output logic [7:0] sOut, output logic cOut, output int lat);
    a8 = aIn; b8 = bIn; inValid8 = 1'b1;
    @(posedge clk); #1;
    inValid8 = 1'b0;
    lat = 0;
    while (!outValid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    sOut = sum8;
    cOut = cout8;
    outReady8 = 1'b1;
    @(posedge clk); #1;
    outReady8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vecCount++;
    if ({inReady8, outValid8, sum8, cout8} !== 11'b0) begin
      missCount++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b sum=%0d cout=%b, expected all 0",
               inReady8, outValid8, sum8, cout8);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vecCount++;
    if (inReady8 !== 1'b1 || outValid8 !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0",
               inReady8, outValid8);
    end
  endtask

  task automatic test_basic();
    logic [7:0] s;
    logic       c;
    int         lat;
    runOp8(8'd3, 8'd5, s, c, lat);
    vecCount++;
    if (s !== 8'd8 || c !== 1'b0 || lat != 8) begin
      missCount++;
      $display("[TB] FAIL basic_3p5: got sum=%0d cout=%b lat=%0d, expected sum=8 cout=0 lat=8",
               s, c, lat);
    end
    vecCount++;
    if (outValid8 !== 1'b0 || inReady8 !== 1'b1 || sum8 !== 8'd8) begin
      missCount++;
      $display("[TB] FAIL basic_handoff: got vld=%b rdy=%b sum=%0d, expected vld=0 rdy=1 sum=8",
               outValid8, inReady8, sum8);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] s;
    logic       c;
    int         lat;
    runOp8(8'd255, 8'd1, s, c, lat);
    vecCount++;
    if (s !== 8'd0 || c !== 1'b1 || lat != 8) begin
      missCount++;
      $display("[TB] FAIL wrap_255p1: got sum=%0d cout=%b lat=%0d, expected sum=0 cout=1 lat=8",
               s, c, lat);
    end
    runOp8(8'hAA, 8'h55, s, c, lat);
    vecCount++;
    if (s !== 8'hFF || c !== 1'b0 || lat != 8) begin
      missCount++;
      $display("[TB] FAIL alt_AAp55: got sum=%0h cout=%b lat=%0d, expected sum=ff cout=0 lat=8",
               s, c, lat);
    end
  endtask

  task automatic test_hold();
    a8 = 8'hF0; b8 = 8'h20; inValid8 = 1'b1;
    @(posedge clk); #1;
    inValid8 = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    vecCount++;
    if (outValid8 !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL hold_early_valid: got vld=%b at 7 cycles, expected 0", outValid8);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      vecCount++;
      if (outValid8 !== 1'b1 || sum8 !== 8'h10 || cout8 !== 1'b1 || inReady8 !== 1'b0) begin
        missCount++;
        $display("[TB] FAIL hold_cycle%0d: got vld=%b sum=%0h cout=%b rdy=%b, expected 1/10/1/0",
                 i, outValid8, sum8, cout8, inReady8);
      end
      inValid8 = (i % 2 == 0);
      a8 = 8'd1; b8 = 8'd1;
      @(posedge clk); #1;
    end
    inValid8 = 1'b0;
    outReady8 = 1'b1;
    @(posedge clk); #1;
    outReady8 = 1'b0;
    vecCount++;
    if (outValid8 !== 1'b0 || sum8 !== 8'h10 || cout8 !== 1'b1 || inReady8 !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL hold_release: got vld=%b sum=%0h cout=%b rdy=%b, expected 0/10/1/1",
               outValid8, sum8, cout8, inReady8);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s;
    logic       c;
    int         lat;
    a8 = 8'hFF; b8 = 8'hFF; inValid8 = 1'b1;
    @(posedge clk); #1;
    inValid8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    vecCount++;
    if (outValid8 !== 1'b0 || sum8 !== 8'd0 || cout8 !== 1'b0 || inReady8 !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL midrun_reset: got vld=%b sum=%0d cout=%b rdy=%b, expected all 0",
               outValid8, sum8, cout8, inReady8);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runOp8(8'd7, 8'd9, s, c, lat);
    vecCount++;
    if (s !== 8'd16 || c !== 1'b0 || lat != 8) begin
      missCount++;
      $display("[TB] FAIL after_reset_7p9: got sum=%0d cout=%b lat=%0d, expected 16/0/8",
               s, c, lat);
    end
  endtask

  task automatic test_back_to_back();
    int         accAt[2];
    logic [7:0] resS[2];
    logic       resC[2];
    int         nAcc = 0;
    int         nRes = 0;
    a8 = 8'd1; b8 = 8'd2; inValid8 = 1'b1; outReady8 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (inReady8 && nAcc < 2) begin accAt[nAcc] = k; nAcc++; end
      if (outValid8 && nRes < 2) begin resS[nRes] = sum8; resC[nRes] = cout8; nRes++; end
      @(posedge clk); #1;
      if (nAcc == 1) begin a8 = 8'd200; b8 = 8'd100; end
      if (nAcc == 2) inValid8 = 1'b0;
    end
    outReady8 = 1'b0;
    inValid8 = 1'b0;
    vecCount++;
    if (nAcc != 2 || nRes != 2) begin
      missCount++;
      $display("[TB] FAIL b2b_counts: got accepts=%0d results=%0d, expected 2/2", nAcc, nRes);
    end else begin
      vecCount++;
      if (accAt[1] - accAt[0] != 10) begin
        missCount++;
        $display("[TB] FAIL b2b_spacing: got %0d cycles, expected 10", accAt[1] - accAt[0]);
      end
      vecCount++;
      if (resS[0] !== 8'd3 || resC[0] !== 1'b0 || resS[1] !== 8'd44 || resC[1] !== 1'b1) begin
        missCount++;
        $display("[TB] FAIL b2b_results: got %0d/%b then %0d/%b, expected 3/0 then 44/1",
                 resS[0], resC[0], resS[1], resC[1]);
      end
    end
  endtask

  task automatic test_exhaustive_w3();
    int lat;
    int total;
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        total = x + y;
        a3 = 3'(x); b3 = 3'(y); inValid3 = 1'b1;
        @(posedge clk); #1;
        inValid3 = 1'b0;
        lat = 0;
        while (!outValid3 && lat < 20) begin
          @(posedge clk); #1;
          lat++;
        end
        vecCount++;
        if (sum3 !== 3'(total) || cout3 !== total[3] || lat != 3) begin
          missCount++;
          $display("[TB] FAIL w3_%0dp%0d: got sum=%0d cout=%b lat=%0d, expected %0d/%b/3",
                   x, y, sum3, cout3, lat, total & 7, total[3]);
        end
        outReady3 = 1'b1;
        @(posedge clk); #1;
        outReady3 = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    test_exhaustive_w3();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
